// File: rtl/systolic_feeder_if.sv
// Load/stream bundle between a matrix source, the systolic feeder and the
// array edges. The master side supplies A rows / B columns and observes the
// skewed edge streams; the slave side is the feeder itself.
interface systolic_feeder_if #(
    parameter int DWIDTH = 32,
    parameter int N      = 3
);
    logic                         in_valid;
    logic                         in_ready;
    logic [N-1:0][DWIDTH-1:0]     a_row;
    logic [N-1:0][DWIDTH-1:0]     b_col;
    logic [N-1:0][DWIDTH-1:0]     west;
    logic [N-1:0][DWIDTH-1:0]     north;
    logic                         busy;
    logic                         done;

    modport master (
        output in_valid, a_row, b_col,
        input  in_ready, west, north, busy, done
    );

    modport slave (
        input  in_valid, a_row, b_col,
        output in_ready, west, north, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Systolic array feeder: loads an NxN A matrix row by row and an NxN B matrix
// column by column, then streams them diagonally skewed onto the west and
// north edges of an NxN systolic array, waits for the array to drain and
// pulses done. Element values pass through untouched.
// Optional feature: define SYSTOLIC_FEEDER_JOBCNT_EN to add a 16-bit
// job_count output counting completed jobs (wraps, cleared by reset).
module systolic_feeder #(
    parameter int DWIDTH = 32,
    parameter int N      = 3
) (
    input  logic                clk,
    input  logic                rstn,
    systolic_feeder_if.slave    bus
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    ,
    output logic [15:0]         job_count
`endif
);
    localparam int SW = $clog2(3 * N) + 1;
    localparam int IW = $clog2(N);
    localparam logic [SW-1:0] LAST_BEAT  = SW'(N - 1);
    localparam logic [SW-1:0] LAST_STEP  = SW'(3 * N - 3);
    localparam logic [SW-1:0] LAST_DRAIN = SW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                     state_q;
    logic [SW-1:0]              beat_q;
    logic [SW-1:0]              step_q;
    logic [N-1:0][DWIDTH-1:0]   west_q;
    logic [N-1:0][DWIDTH-1:0]   north_q;
    logic [N-1:0][DWIDTH-1:0]   west_d;
    logic [N-1:0][DWIDTH-1:0]   north_d;
    logic                       in_ready_q;
    logic                       busy_q;
    logic                       done_q;

    logic [DWIDTH-1:0]          a_mem [N][N];
    logic [DWIDTH-1:0]          b_mem [N][N];
    logic [IW-1:0]              wr_idx;
    logic [IW-1:0]              kidx;
    int                         nxt_step;
    logic                       accept;

    assign accept   = bus.in_valid & in_ready_q;
    assign wr_idx   = beat_q[IW-1:0];
    // Step whose values are registered at the coming edge: 0 when entering
    // FEED from LOAD, otherwise the following step of the current FEED.
    assign nxt_step = (state_q == S_FEED) ? int'(step_q) + 1 : 0;

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.west     = west_q;
    assign bus.north    = north_q;

    // Capture beat k as A row k and B column k; matrices need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < N; c++) begin
                a_mem[wr_idx][c] <= bus.a_row[c];
                b_mem[c][wr_idx] <= bus.b_col[c];
            end
        end
    end

    // Diagonal skew: edge lane i carries element (step - i) of its row/column.
    always_comb begin
        west_d  = '0;
        north_d = '0;
        kidx    = '0;
        for (int i = 0; i < N; i++) begin
            if (nxt_step >= i && nxt_step < i + N) begin
                kidx       = IW'(nxt_step - i);
                west_d[i]  = a_mem[i][kidx];
                north_d[i] = b_mem[kidx][i];
            end
        end
    end

    // Job sequencer with registered handshake, status and edge streams.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            step_q     <= '0;
            west_q     <= '0;
            north_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            west_q  <= '0;
            north_q <= '0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= S_LOAD;
                        beat_q  <= SW'(1);
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q    <= S_FEED;
                            beat_q     <= '0;
                            step_q     <= '0;
                            in_ready_q <= 1'b0;
                            west_q     <= west_d;
                            north_q    <= north_d;
                        end else begin
                            beat_q <= beat_q + SW'(1);
                        end
                    end
                end
                S_FEED: begin
                    if (step_q == LAST_STEP) begin
                        state_q <= S_DRAIN;
                        step_q  <= '0;
                    end else begin
                        step_q  <= step_q + SW'(1);
                        west_q  <= west_d;
                        north_q <= north_d;
                    end
                end
                S_DRAIN: begin
                    if (step_q == LAST_DRAIN) begin
                        state_q <= S_DONE;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        step_q <= step_q + SW'(1);
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    beat_q     <= '0;
                    step_q     <= '0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    logic [15:0] job_count_q;

    assign job_count = job_count_q;

    // Count completed jobs; the new value appears the cycle after done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            job_count_q <= '0;
        end else if (done_q) begin
            job_count_q <= job_count_q + 16'd1;
        end
    end
`endif

endmodule
